// File: rtl/hilotof_pkg.sv
// Shared constants for the HiLoTOF result path.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package hilotof_pkg;

    // Width of one DUT result word as seen by the host I/O serialiser
    localparam int HILOTOF_WORD_WIDTH = 32;

endpackage

// File: rtl/hilotof_fifo_mem.sv
// Simple dual-port DEPTH x WIDTH storage, synchronous write, asynchronous read (distributed RAM).
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller only writes when a slot is free.
module hilotof_fifo_mem
    import hilotof_pkg::*;
#(
    parameter int WIDTH = HILOTOF_WORD_WIDTH,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is not reset; the top masks the read port while empty
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hilotof_result_fifo.sv
// First-word-fall-through result buffer between the DUT result port and the host I/O block.
// Latency: a word pushed into an empty FIFO is on out_data with out_valid=1 one edge later.
// Backpressure: in_ready drops when full; words offered while full are dropped and set overflow.
// Optional macro HILOTOF_RESULT_FIFO_STATS_EN adds high_water and drop_count outputs.
module hilotof_result_fifo
    import hilotof_pkg::*;
#(
    parameter int WIDTH = HILOTOF_WORD_WIDTH,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       sys_reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
`ifdef HILOTOF_RESULT_FIFO_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] high_water,
    output logic [15:0]                drop_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_nxt;
    logic [WIDTH-1:0] mem_rdata;
    logic             push;
    logic             pop;
    logic             drop;

    // in_ready and out_valid are flops, so neither handshake has a combinational path
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
    assign drop = in_valid && !in_ready;

    // Occupancy after this edge; push+pop together leaves it unchanged
    always_comb begin
        level_nxt = level;
        unique case ({push, pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    // Pointers, occupancy and flags; full/empty come from level so pointers may wrap freely
    always_ff @(posedge clock) begin
        if (sys_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            in_ready  <= (level_nxt != LW'(DEPTH));
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    hilotof_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Head slot cannot be overwritten while valid (writes stop at full), so out_data is stable
    // under stall; it reads zero while empty so reset and idle never expose stale storage.
    assign out_data = out_valid ? mem_rdata : '0;

`ifdef HILOTOF_RESULT_FIFO_STATS_EN
    // Peak occupancy since reset and saturating count of dropped words
    always_ff @(posedge clock) begin
        if (sys_reset) begin
            high_water <= '0;
            drop_count <= '0;
        end else begin
            if (level_nxt > high_water) begin
                high_water <= level_nxt;
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule
